// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the 16-bit SRAM memory-stage controller.
package sram_pkg;
  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
  // 32-bit word index relative to base; out-of-range addresses wrap.
  function automatic logic [SRAM_AW-2:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (SRAM_AW-1)'((addr - base) >> 2);
  endfunction
endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if: MEM-stage request/response bundle between pipeline and SRAM controller.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_io.sv
// sram_io: tri-state buffer for the SRAM data bus.
module sram_io import sram_pkg::*; (
  input  logic               en_i,
  input  logic [SRAM_DW-1:0] d_i,
  output logic [SRAM_DW-1:0] q_o,
  inout  wire  [SRAM_DW-1:0] pad_io
);
  assign pad_io = en_i ? d_i : {SRAM_DW{1'bz}};
  assign q_o = pad_io;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: services 32-bit loads/stores as two half-word accesses to a 16-bit async SRAM.
module sram_controller import sram_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = SRAM_BASE_ADDR,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);
  state_e state_q;
  op_e op_q;
  logic [2:0] cnt_q;
  logic [31:0] addr_q, data_q, rdata_q;
  logic dq_en_q, req, last;
  logic [SRAM_DW-1:0] dq_in;
  assign req = bus.rd_en | bus.wr_en;
  assign last = cnt_q == 3'(ACCESS_CYCLES - 1);
  // DONE releases the freeze even while the request is still held.
  assign bus.ready = !(req && state_q != DONE);
  assign bus.read_data = rdata_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  sram_io u_io (
    .en_i   (dq_en_q),
    .d_i    (state_q == HIGH ? data_q[31:16] : data_q[15:0]),
    .q_o    (dq_in),
    .pad_io (SRAM_DQ)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= OP_RD;
      addr_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
      dq_en_q <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_CE_N <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          state_q <= LOW;
          cnt_q <= '0;
          op_q <= bus.wr_en ? OP_WR : OP_RD;
          addr_q <= bus.address;
          data_q <= bus.write_data;
          dq_en_q <= bus.wr_en;
          SRAM_ADDR <= {word_index(bus.address, BASE_ADDR), 1'b0};
          SRAM_WE_N <= !bus.wr_en;
          SRAM_OE_N <= bus.wr_en;
          SRAM_CE_N <= 1'b0;
        end
        LOW: if (last) begin
          state_q <= HIGH;
          cnt_q <= '0;
          if (op_q == OP_RD) rdata_q[15:0] <= dq_in;
          SRAM_ADDR <= {word_index(addr_q, BASE_ADDR), 1'b1};
        end else cnt_q <= cnt_q + 3'd1;
        HIGH: if (last) begin
          state_q <= DONE;
          cnt_q <= '0;
          if (op_q == OP_RD) rdata_q[31:16] <= dq_in;
          dq_en_q <= 1'b0;
          SRAM_WE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          SRAM_CE_N <= 1'b1;
        end else cnt_q <= cnt_q + 3'd1;
        DONE: begin
          state_q <= IDLE;
          cnt_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed + randomized checks of the SRAM controller against a word-level model.
module tb_sram_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  sram_controller_if b2 ();
  sram_controller_if b1 ();
  wire [15:0] dq2, dq1;
  logic [17:0] a2, a1;
  logic we2, oe2, ce2, ub2, lb2, we1, oe1, ce1, ub1, lb1;
  sram_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(b2), .SRAM_DQ(dq2), .SRAM_ADDR(a2),
    .SRAM_WE_N(we2), .SRAM_OE_N(oe2), .SRAM_CE_N(ce2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2)
  );
  sram_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .SRAM_DQ(dq1), .SRAM_ADDR(a1),
    .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
  );
  // Half-word SRAM models; probe overrides the bus to show the controller has released it.
  logic [15:0] mem [0:262143];
  logic probe = 1'b0;
  assign dq2 = probe ? 16'hA5C3 : (!ce2 && !oe2 && we2) ? mem[a2] : 16'hzzzz;
  always @(posedge clk) if (!ce2 && !we2) mem[a2] <= dq2;
  assign dq1 = (!ce1 && !oe1 && we1) ? (a1[15:0] ^ 16'h5A5A) : 16'hzzzz;

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_rd = 32'h0;
  logic [31:0] ref_mem [logic [16:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'd1024) / 4;
    return off[16:0];
  endfunction

  task automatic check_release(input string tag);
    probe = 1'b1;
    #1 chk(tag, dq2, 16'hA5C3);
    probe = 1'b0;
  endtask

  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] wd, output int done_cyc);
    logic [16:0] idx;
    idx = widx(a);
    @(posedge clk); #1;
    b2.wr_en = w; b2.rd_en = r; b2.address = a; b2.write_data = wd;
    #1 chk("ready_c0", b2.ready, 0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #2;
      chk("ready_stall", b2.ready, 0);
      chk("ce_n_active", ce2, 0);
      chk("sram_addr", a2, {idx, c > 2});
      chk("we_n_active", we2, !w);
      chk("oe_n_active", oe2, w);
      if (w) chk("dq_write", dq2, c > 2 ? wd[31:16] : wd[15:0]);
    end
    if (w) ref_mem[idx] = wd;
    else exp_rd = ref_mem[idx];
    @(posedge clk); #2;
    done_cyc = cyc;
    chk("ready_done", b2.ready, 1);
    chk("ce_n_done", ce2, 1);
    chk("we_n_done", we2, 1);
    chk("oe_n_done", oe2, 1);
    chk("read_data", b2.read_data, exp_rd);
    check_release("dq_release_done");
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      b2.wr_en = 1'b0; b2.rd_en = 1'b0;
      #1 chk("ready_idle", b2.ready, 1);
      chk("rd_hold_idle", b2.read_data, exp_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d1, d2;
    logic [31:0] pool [8];
    logic [31:0] a;
    logic [16:0] i1;
    logic w, r;
    pool = '{32'd1044, 32'd1060, 32'd1020, 32'd0, 32'hFFFF_FFFC, 32'd1052 + (32'd1 << 19), 32'd1052, 32'h1234_5678};
    b2.wr_en = 0; b2.rd_en = 0; b2.address = 0; b2.write_data = 0;
    b1.wr_en = 0; b1.rd_en = 0; b1.address = 0; b1.write_data = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", b2.ready, 1);
    chk("rst_ce_n", ce2, 1);
    chk("rst_we_n", we2, 1);
    chk("rst_oe_n", oe2, 1);
    chk("rst_ub_lb", {ub2, lb2}, 0);
    chk("rst_read_data", b2.read_data, 0);
    check_release("rst_dq_release");
    rst = 1'b0;
    // Store then load through the wrapped pair of half-words.
    access(1, 0, 32'd1028, 32'hDEADBEEF, d1);
    idle(1);
    access(0, 1, 32'd1028, 32'h0, d1);
    chk("load_deadbeef", b2.read_data, 32'hDEADBEEF);
    idle(3);
    access(1, 0, 32'd1024, 32'h1111_2222, d1);
    access(1, 0, 32'd1036, 32'h3333_4444, d1);
    chk("rd_after_store", b2.read_data, 32'hDEADBEEF);
    access(1, 1, 32'd1032, 32'h0BAD_F00D, d1);
    idle(1);
    // Back-to-back loads complete 2*ACCESS_CYCLES+2 apart.
    access(0, 1, 32'd1024, 32'h0, d1);
    access(0, 1, 32'd1036, 32'h0, d2);
    chk("b2b_spacing", d2 - d1, 6);
    chk("b2b_data", b2.read_data, 32'h3333_4444);
    idle(1);
    // Reset during the HIGH half of a store.
    @(posedge clk); #1;
    b2.wr_en = 1; b2.address = 32'd1424; b2.write_data = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #2 chk("pre_rst_addr_high", a2, {widx(32'd1424), 1'b1});
    chk("pre_rst_we_n", we2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("abort_ready_idle", b2.ready, 0);
    chk("abort_we_n", we2, 1);
    chk("abort_ce_n", ce2, 1);
    chk("abort_read_data", b2.read_data, 0);
    check_release("abort_dq_release");
    b2.wr_en = 0;
    exp_rd = 32'h0;
    idle(1);
    // ACCESS_CYCLES=1 instance: request dropped after cycle 0 still completes.
    i1 = widx(32'd1024 + 4 * 32'h123);
    @(posedge clk); #1;
    b1.rd_en = 1; b1.address = 32'd1024 + 4 * 32'h123;
    #1 chk("ac1_ready_c0", b1.ready, 0);
    @(posedge clk); #1;
    b1.rd_en = 0;
    #1 chk("ac1_low_ce", ce1, 0);
    chk("ac1_low_addr", a1, {i1, 1'b0});
    chk("ac1_low_oe", oe1, 0);
    chk("ac1_ready_dropped", b1.ready, 1);
    @(posedge clk); #2;
    chk("ac1_high_ce", ce1, 0);
    chk("ac1_high_addr", a1, {i1, 1'b1});
    @(posedge clk); #1;
    b1.rd_en = 1; b1.address = 32'd1028;
    #1 chk("ac1_done_ready", b1.ready, 1);
    chk("ac1_done_ce", ce1, 1);
    chk("ac1_read_data", b1.read_data, {16'({i1, 1'b1}) ^ 16'h5A5A, 16'({i1, 1'b0}) ^ 16'h5A5A});
    @(posedge clk); #2 chk("ac1_idle_ready", b1.ready, 0);
    @(posedge clk); #2 chk("ac1_low2_ready", b1.ready, 0);
    @(posedge clk); #2 chk("ac1_high2_ready", b1.ready, 0);
    @(posedge clk); #2 chk("ac1_done2_ready", b1.ready, 1);
    chk("ac1_read_data2", b1.read_data, {16'h0003 ^ 16'h5A5A, 16'h0002 ^ 16'h5A5A});
    @(posedge clk); #1 b1.rd_en = 0;
    // Random traffic over a pool that includes wrapped and aliased addresses.
    foreach (pool[k]) access(1, 0, pool[k], $urandom, d1);
    repeat (24) begin
      a = pool[$urandom_range(0, 7)];
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (!w) r = 1'b1;
      access(w, r, a, $urandom, d1);
      idle($urandom_range(0, 2));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage controller that services 32-bit MIPS load/store requests against an external 16-bit asynchronous SRAM using two half-word accesses per request. It sits between the EXE/MEM pipeline register and the MEM/WB pipeline register. It drives `ready`, which the top level inverts into the pipeline-wide `Freeze`, so every pipeline register holds while an access is in flight. `read_data` feeds the MEM/WB register's memory-data input.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `ACCESS_CYCLES`, 2: clock cycles held per half-word access; legal range 1..7.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wr_en`  in  1  store request from the MEM stage; held while `ready`=0.
- `rd_en`  in  1  load request from the MEM stage; held while `ready`=0.
- `address`  in  32  byte address from the ALU result.
- `write_data`  in  32  store data.
- `read_data`  out  32  registered load result.
- `ready`  out  1  1 = no access pending or access completing this cycle; 0 = freeze the pipeline.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  active-low SRAM strobes.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- **IDLE**
  - `rd_en|wr_en`=1 → latch `op_q` (write if `wr_en`, else read), `addr_q`, and `data_q`; go to LOW.
  - `wr_en` has priority when both are high.
- **LOW**: hold for `ACCESS_CYCLES` cycles, then go to HIGH.
- **HIGH**: hold for `ACCESS_CYCLES` cycles, then go to DONE.
- **DONE**: one cycle, then always go to IDLE.
- Word index = (`addr_q` − `BASE_ADDR`) >> 2, truncated to 17 bits, so out-of-range addresses wrap.
- `SRAM_ADDR` = {index, 0} in LOW and {index, 1} in HIGH.
- Low SRAM half-word holds data bits [15:0]; high SRAM half-word holds bits [31:16].
- Read:
  - `SRAM_OE_N`=0 in LOW and HIGH.
  - `read_data[15:0]` is captured from `SRAM_DQ` on the last LOW cycle.
  - `read_data[31:16]` is captured on the last HIGH cycle.
  - Both halves hold until the next read overwrites them; writes never change `read_data`.
- Write:
  - `SRAM_WE_N`=0 in LOW and HIGH.
  - `SRAM_DQ` is driven with `data_q[15:0]` in LOW and `data_q[31:16]` in HIGH.
  - `SRAM_DQ` is high-Z in every other state and for reads.
- `SRAM_CE_N`=0 in LOW and HIGH, else 1.
- `SRAM_UB_N` and `SRAM_LB_N` are always 0.
- `ready` is combinational: `ready` = !((`rd_en`|`wr_en`) && state≠DONE).
- A request that deasserts mid-access still completes using the latched values.
- Reset values:
  - state IDLE, counter 0, `read_data` 0.
  - `op_q`, `addr_q`, `data_q` 0.
  - Strobes all 1 except UB_N/LB_N = 0; `SRAM_DQ` high-Z.
  - `ready` then follows its formula.
- Reset mid-access aborts immediately; the SRAM is released in the same edge.

## Timing
- With a request first visible in cycle 0 (state IDLE), `ready`=0 for cycles 0..2·`ACCESS_CYCLES`.
- `ready`=1 in cycle 2·`ACCESS_CYCLES`+1 (DONE); `read_data` is valid in that cycle.
- Default parameters: 5 stall cycles, with `ready` high in cycle 5.
- The MEM/WB register captures `read_data` at the end of the DONE cycle.
- A back-to-back request, visible the cycle after DONE, restarts from IDLE; completion-to-completion spacing is 2·`ACCESS_CYCLES`+2.
- `ready` responds combinationally to `rd_en`/`wr_en` in the same cycle; no request is ever missed.
- Counter width is 3 bits; it clears on every state change.

## Structure
- Package `sram_pkg` holds:
  - the state enum (IDLE/LOW/HIGH/DONE);
  - `SRAM_AW`=18 and `SRAM_DW`=16;
  - the default `BASE_ADDR`.
- Sub-module `sram_io`: the tri-state DQ buffer, with a drive enable, 16-bit out data, and 16-bit in data.
- FSM, counter, and capture registers live in `sram_controller`.

## Test plan
- Reset asserted during a write in HIGH → next cycle: state IDLE, `SRAM_WE_N`=1, `SRAM_CE_N`=1, `SRAM_DQ` Z, `read_data`=0.
- Store `write_data`=0xDEADBEEF at `address`=1028 (defaults):
  - `ready` low cycles 0–4;
  - `SRAM_ADDR`=2 carries 0xBEEF and `SRAM_ADDR`=3 carries 0xDEAD, with `SRAM_WE_N`=0;
  - `ready` high in cycle 5.
- Load from 1028 after that store, with an SRAM behavioral model → `read_data`=0xDEADBEEF in cycle 5; it stays there through a following idle period and a store.
- `rd_en` and `wr_en` both high at 1032 → write performed (`SRAM_ADDR` 4/5, `SRAM_OE_N`=1); `read_data` unchanged.
- Back-to-back loads at 1024 and 1036 → completions 6 cycles apart; second access uses `SRAM_ADDR` 6/7.
- `ACCESS_CYCLES`=1, `rd_en` dropped after cycle 0 → access still runs; LOW and HIGH last one cycle each; DONE in cycle 3.
